// File: rtl/bcd_pkg.sv
// bcd_pkg: state encodings and BCD helpers shared by the digit chain sequencer and its cells.
package bcd_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_TERM  = 2'd3;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one decimal digit with clear/load/increment, clear taking priority over load.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       is9
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (ld)
            q <= bcd_sat(ld_val);
        else if (en)
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end

    assign is9 = q == BCD_MAX;
endmodule

// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl: run/pause/terminal sequencer, prescaler and carry-enable chain
// for a cascade of single-digit BCD counters.
module bcd_chain_ctrl
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 10,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    term,
    output logic [1:0]              state
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]         psc;
    logic [NUM_DIGITS-1:0] is9;
    logic [NUM_DIGITS:0]   carry;
    logic                  tick, terminal, ld_ok;

    always_comb begin
        tick     = (state == ST_RUN) && (psc == PS_LAST);
        terminal = tick && (&is9);
        ld_ok    = load && (state == ST_IDLE || state == ST_PAUSE);
        // A non-wrapping terminal tick freezes the digits at all-9s.
        carry[0] = tick && !clear && !(terminal && !WRAP);
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign carry[g+1] = carry[g] && is9[g];
        bcd_digit_cell u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (carry[g]),
            .clr    (clear),
            .ld     (ld_ok),
            .ld_val (load_val[4*g +: 4]),
            .q      (digits[4*g +: 4]),
            .is9    (is9[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            psc     <= '0;
            running <= 1'b0;
            term    <= 1'b0;
        end else if (clear) begin
            state   <= ST_IDLE;
            psc     <= '0;
            running <= 1'b0;
            term    <= 1'b0;
        end else begin
            term <= terminal;
            if (state == ST_RUN)
                psc <= (psc == PS_LAST) ? '0 : psc + 1'b1;
            case (state)
                ST_IDLE, ST_PAUSE: if (!load && !stop && start) begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
                ST_RUN: if (terminal && !WRAP) begin
                    state   <= ST_TERM;
                    running <= 1'b0;
                end else if (stop) begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ld_ok is consumed by the cells; keep it visible here for load gating only.
    logic unused_ok;
    assign unused_ok = ld_ok;
endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// tb_bcd_chain_ctrl: four parameterisations driven in parallel, checked every cycle against
// an integer-valued decimal counter model plus directed literal expectations.
module tb_bcd_chain_ctrl;
    localparam int NN [4] = '{2, 4, 4, 4};
    localparam int NP [4] = '{3, 1, 1, 4};
    localparam int NW [4] = '{1, 1, 0, 1};

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [7:0]  dig_a;
    logic [15:0] dig_b, dig_c, dig_d;
    logic [1:0]  st_a, st_b, st_c, st_d;
    logic        run_a, run_b, run_c, run_d, term_a, term_b, term_c, term_d;

    int checks = 0, fails = 0;
    int m_val [4], m_st [4], m_psc [4];
    bit m_term [4];

    always #5 clk = ~clk;

    bcd_chain_ctrl #(.NUM_DIGITS(2), .PRESCALE(3), .WRAP(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val[7:0]), .digits(dig_a), .running(run_a), .term(term_a), .state(st_a));
    bcd_chain_ctrl #(.NUM_DIGITS(4), .PRESCALE(1), .WRAP(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .digits(dig_b), .running(run_b), .term(term_b), .state(st_b));
    bcd_chain_ctrl #(.NUM_DIGITS(4), .PRESCALE(1), .WRAP(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .digits(dig_c), .running(run_c), .term(term_c), .state(st_c));
    bcd_chain_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .WRAP(1'b1)) u_d (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .digits(dig_d), .running(run_d), .term(term_d), .state(st_d));

    function automatic int max_of(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r - 1;
    endfunction

    function automatic int sat_val(input logic [15:0] lv, input int n);
        int r = 0, w = 1;
        for (int k = 0; k < n; k++) begin
            int d = int'(lv[4*k +: 4]);
            r = r + ((d > 9) ? 9 : d) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal-counter reference: value held as an integer, ticks every PRESCALE RUN cycles.
    always @(posedge clk or negedge reset_n) begin
        bit tk, tm;
        int nv, ns;
        for (int i = 0; i < 4; i++) begin
            if (!reset_n || clear) begin
                m_val[i] <= 0; m_st[i] <= 0; m_psc[i] <= 0; m_term[i] <= 0;
            end else begin
                tk = m_st[i] == 1 && m_psc[i] == NP[i] - 1;
                tm = tk && m_val[i] == max_of(NN[i]);
                nv = m_val[i];
                ns = m_st[i];
                if (load && (m_st[i] == 0 || m_st[i] == 2)) nv = sat_val(load_val, NN[i]);
                else if (tm) nv = NW[i] ? 0 : m_val[i];
                else if (tk) nv = m_val[i] + 1;
                if ((m_st[i] == 0 || m_st[i] == 2) && !load && !stop && start) ns = 1;
                else if (m_st[i] == 1 && tm && NW[i] == 0) ns = 3;
                else if (m_st[i] == 1 && stop) ns = 2;
                m_val[i] <= nv;
                m_st[i] <= ns;
                m_term[i] <= tm;
                if (m_st[i] == 1) m_psc[i] <= (m_psc[i] + 1) % NP[i];
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [15:0] d, input logic [1:0] s,
                            input logic r, input logic t);
        chk($sformatf("m%0d_digits", i), 32'(d), 32'(to_bcd(m_val[i])));
        chk($sformatf("m%0d_state", i), 32'(s), 32'(m_st[i]));
        chk($sformatf("m%0d_running", i), 32'(r), 32'(m_st[i] == 1));
        chk($sformatf("m%0d_term", i), 32'(t), 32'(m_term[i]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, {8'h00, dig_a}, st_a, run_a, term_a);
        cmp_inst(1, dig_b, st_b, run_b, term_b);
        cmp_inst(2, dig_c, st_c, run_c, term_c);
        cmp_inst(3, dig_d, st_d, run_d, term_d);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_digits", 32'(dig_b), 32'h0);
        chk("rst_state", 32'(st_b), 32'h0);
        chk("rst_running", 32'(run_b), 32'h0);
        chk("rst_term", 32'(term_b), 32'h0);
        reset_n = 1'b1;
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t1_running", 32'(run_a), 32'h1);
        cyc(3); chk("t1_01", 32'(dig_a), 32'h01);
        cyc(3); chk("t1_02", 32'(dig_a), 32'h02);
        cyc(24); chk("t1_10", 32'(dig_a), 32'h10);

        clear = 1'b1; cyc(1); clear = 1'b0;
        load = 1'b1; load_val = 16'h9999; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t2_pre", 32'(dig_b), 32'h9999);
        cyc(1);
        chk("t2_wrap", 32'(dig_b), 32'h0000);
        chk("t2_term", 32'(term_b), 32'h1);
        chk("t2_state", 32'(st_b), 32'h1);
        cyc(1);
        chk("t2_term_drop", 32'(term_b), 32'h0);
        chk("t2_next", 32'(dig_b), 32'h0001);

        clear = 1'b1; cyc(1); clear = 1'b0;
        load = 1'b1; load_val = 16'h0998; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t3_0998", 32'(dig_c), 32'h0998);
        cyc(1); chk("t3_0999", 32'(dig_c), 32'h0999);
        cyc(1); chk("t3_1000", 32'(dig_c), 32'h1000);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t3_pause", 32'(st_c), 32'h2);
        chk("t3_stop_tick", 32'(dig_c), 32'h1001);
        load = 1'b1; load_val = 16'h9999; cyc(1); load = 1'b0;
        chk("t3_load", 32'(dig_c), 32'h9999);
        start = 1'b1; cyc(1);
        chk("t3_run", 32'(st_c), 32'h1);
        cyc(1);
        chk("t3_term_state", 32'(st_c), 32'h3);
        chk("t3_term_hold", 32'(dig_c), 32'h9999);
        chk("t3_term_pulse", 32'(term_c), 32'h1);
        chk("t3_term_running", 32'(run_c), 32'h0);
        cyc(1);
        chk("t3_term_drop", 32'(term_c), 32'h0);
        chk("t3_start_ignored", 32'(st_c), 32'h3);
        start = 1'b0; load = 1'b1; load_val = 16'h0000; cyc(1); load = 1'b0;
        chk("t3_load_ignored", 32'(dig_c), 32'h9999);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("t3_clear_state", 32'(st_c), 32'h0);
        chk("t3_clear_digits", 32'(dig_c), 32'h0);

        start = 1'b1; cyc(1); start = 1'b0;
        cyc(20); chk("t4_0005", 32'(dig_d), 32'h0005);
        cyc(2);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t4_pause", 32'(st_d), 32'h2);
        cyc(2); chk("t4_frozen", 32'(dig_d), 32'h0005);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t4_resume", 32'(st_d), 32'h1);
        chk("t4_still5", 32'(dig_d), 32'h0005);
        cyc(1); chk("t4_0006", 32'(dig_d), 32'h0006);

        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t5_pause", 32'(st_b), 32'h2);
        load = 1'b1; load_val = 16'hF3A7; cyc(1); load = 1'b0;
        chk("t5_sat", 32'(dig_b), 32'h9397);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_resume", 32'(dig_b), 32'h9397);
        load = 1'b1; load_val = 16'h1234; cyc(1); load = 1'b0;
        chk("t5_run_load", 32'(dig_b), 32'h9398);
        clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
        chk("t5_clr_state", 32'(st_b), 32'h0);
        chk("t5_clr_digits", 32'(dig_b), 32'h0);

        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        @(posedge clk); #2 reset_n = 1'b0; #1;
        chk("t6_digits", 32'(dig_b), 32'h0);
        chk("t6_state", 32'(st_b), 32'h0);
        chk("t6_running", 32'(run_b), 32'h0);
        chk("t6_digits_d", 32'(dig_d), 32'h0);
        @(negedge clk); reset_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            reset_n  = ($urandom_range(0, 599) != 0);
            clear    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 6);
            load_val = $urandom_range(0, 1) ? 16'($urandom) : {12'h999, 4'($urandom_range(0, 15))};
            stop     = ($urandom_range(0, 99) < 5);
            start    = ($urandom_range(0, 99) < 15);
        end
        @(negedge clk);
        reset_n = 1'b1; clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
